// File: rtl/adder_16bit_pkg.sv
// Shared constants and helpers for the 16-bit saturating adder/subtractor.
package adder_16bit_pkg;

    localparam int unsigned      WIDTH      = 16;
    localparam logic [WIDTH-1:0] SAT_POS    = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG    = 16'h8000;
    localparam int unsigned      SLICE_W    = 4;
    localparam int unsigned      NUM_SLICES = WIDTH / SLICE_W;

    // Clamp direction follows the sign of A: overflow can only push away from A's sign.
    function automatic logic [WIDTH-1:0] sat_value(input logic sign_a);
        return sign_a ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice; all internal carries are computed in parallel from cin.
module cla_4bit
    import adder_16bit_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s = w_p ^ w_c;

endmodule

// File: rtl/adder_16bit.sv
// Registered 16-bit two's-complement add/subtract with signed saturation.
// Four CLA slices rippled together produce the raw result; overflow is sign-based.
module adder_16bit
    import adder_16bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum,
    output logic             Overflow
);

    logic [WIDTH-1:0]      w_b_eff;
    logic [WIDTH-1:0]      w_raw;
    logic [NUM_SLICES-1:0] w_cin;
    logic [NUM_SLICES-1:0] w_cout;
    logic                  w_unused_cout;
    logic                  w_ovf;
    logic [WIDTH-1:0]      w_sum_d;
    logic [WIDTH-1:0]      r_sum;
    logic                  r_ovf;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as slice 0's carry-in.
    assign w_b_eff = Sub ? ~B : B;
    assign w_cin   = {w_cout[NUM_SLICES-2:0], Sub};

    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
        cla_4bit u_cla (
            .a    (A[gi*SLICE_W +: SLICE_W]),
            .b    (w_b_eff[gi*SLICE_W +: SLICE_W]),
            .cin  (w_cin[gi]),
            .s    (w_raw[gi*SLICE_W +: SLICE_W]),
            .cout (w_cout[gi])
        );
    end

    // Final carry-out plays no part in overflow detection.
    assign w_unused_cout = w_cout[NUM_SLICES-1];

    assign w_ovf = (Sub ? (A[WIDTH-1] != B[WIDTH-1]) : (A[WIDTH-1] == B[WIDTH-1]))
                 && (w_raw[WIDTH-1] != A[WIDTH-1]);

    assign w_sum_d = w_ovf ? sat_value(A[WIDTH-1]) : w_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_sum <= w_sum_d;
            r_ovf <= w_ovf;
        end
    end

    assign Sum      = r_sum;
    assign Overflow = r_ovf;

endmodule

// File: tb/tb_adder_16bit.sv
// Scoreboard bench for adder_16bit: driver pushes expected results, monitor pops and compares.
module tb_adder_16bit;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Sub;
    logic [15:0] Sum;
    logic        Overflow;

    int n_vec;
    int n_miss;
    logic [16:0] exp_q[$];

    adder_16bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Sub      (Sub),
        .Sum      (Sum),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then clamp to the signed 16-bit range.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub);
        int sa;
        int sb;
        int r;
        logic [31:0] ru;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        ru = 32'(r);
        return {1'b0, ru[15:0]};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got Sum=%h Ovf=%b, expected Sum=%h Ovf=%b",
                     name, got[15:0], got[16], want[15:0], want[16]);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sub);
        A   = a;
        B   = b;
        Sub = sub;
        exp_q.push_back(model(a, b, sub));
    endtask

    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic sub);
        @(negedge clk);
        drive(a, b, sub);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] corners[6];
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return 16'($urandom);
    endfunction

    // Monitor: one result per cycle whenever a transaction is outstanding.
    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            check("pipe", {Overflow, Sum}, exp_q.pop_front());
        end
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b1;
        A   = 16'h0000;
        B   = 16'h0000;
        Sub = 1'b0;
        #3;
        check("reset_state", {Overflow, Sum}, 17'h0_0000);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, back to back with no bubbles.
        apply(16'h7FFC, 16'h000F, 1'b0);
        apply(16'h8007, 16'h0558, 1'b0);
        apply(16'h8007, 16'h7FFC, 1'b1);
        apply(16'h1234, 16'h0558, 1'b1);
        apply(16'h8000, 16'h8000, 1'b0);
        apply(16'hFFFF, 16'h0001, 1'b0);
        apply(16'h7FFF, 16'hFFFF, 1'b1);
        apply(16'h8000, 16'h0001, 1'b1);

        for (int i = 0; i < 300; i++) begin
            apply(pick(), pick(), 1'($urandom_range(1)));
        end

        // Async reset immediately clears a captured overflow result.
        apply(16'h0000, 16'h8000, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", {Overflow, Sum}, 17'h0_0000);

        // First edge after release captures the inputs present at that edge.
        @(negedge clk);
        rst = 1'b0;
        drive(16'h1234, 16'h0558, 1'b1);

        // Reset during an in-flight operation discards it.
        @(negedge clk);
        drive(16'h7FFC, 16'h000F, 1'b0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_midop", {Overflow, Sum}, 17'h0_0000);
        @(posedge clk);
        #2;
        check("rst_held", {Overflow, Sum}, 17'h0_0000);

        @(negedge clk);
        rst = 1'b0;
        drive(16'h8000, 16'h8000, 1'b0);
        apply(16'hFFFF, 16'h0001, 1'b0);
        apply(16'h0000, 16'h8000, 1'b1);
        @(negedge clk);
        @(negedge clk);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
